// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the 5-stage pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // x0 is hardwired to zero, so it never matches a producer.
    function automatic logic reg_match(input logic [4:0] wa, input logic [4:0] rs);
        return (wa != REG_ZERO) && (wa == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// E-stage operand forwarding select for one source operand; M has priority over W.
module forward_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] rs_E,
    input  logic [4:0] wa_M,
    input  logic       we_M,
    input  logic [4:0] wa_W,
    input  logic       we_W,
    output fwd_sel_e   fwd_sel
);

    // Select the youngest in-flight producer of rs_E.
    always_comb begin
        fwd_sel = FWD_RF;
        if (we_M && reg_match(wa_M, rs_E)) begin
            fwd_sel = FWD_M;
        end else if (we_W && reg_match(wa_W, rs_E)) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forwarding controller with data-memory wait FSM and timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit performance counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] register_file_WA_E,
    input  logic [4:0] register_file_WA_M,
    input  logic [4:0] register_file_WA_W,
    input  logic       ctrl_register_file_WE_M,
    input  logic       ctrl_register_file_WE_W,
    input  logic       ctrl_result_E,
    input  logic       ctrl_branch_M,
    input  logic       ALU_zero_M,
    input  logic       dmem_req_M,
    input  logic       dmem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_M,
    output logic       flush_W,
    output logic [1:0] forward_A_E,
    output logic [1:0] forward_B_E,
    output logic       pc_src,
    output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_timeouts
`endif
);

    hz_state_e        state_r;
    hz_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             mem_err_r;
    logic             mem_wait_s;
    logic             timeout_s;
    logic             run_s;
    logic             branch_s;
    logic             load_use_s;
    fwd_sel_e         fwd_a_s;
    fwd_sel_e         fwd_b_s;

    forward_sel u_fwd_a (
        .rs_E    (rs1_E),
        .wa_M    (register_file_WA_M),
        .we_M    (ctrl_register_file_WE_M),
        .wa_W    (register_file_WA_W),
        .we_W    (ctrl_register_file_WE_W),
        .fwd_sel (fwd_a_s)
    );

    forward_sel u_fwd_b (
        .rs_E    (rs2_E),
        .wa_M    (register_file_WA_M),
        .we_M    (ctrl_register_file_WE_M),
        .wa_W    (register_file_WA_W),
        .we_W    (ctrl_register_file_WE_W),
        .fwd_sel (fwd_b_s)
    );

    assign forward_A_E = fwd_a_s;
    assign forward_B_E = fwd_b_s;
    assign mem_err     = mem_err_r;

    // Memory-wait sequencing: wait counter and timeout detection.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mem_wait_s  = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (dmem_req_M && !dmem_ready) begin
                    state_nxt_s = MEM_WAIT;
                    cnt_nxt_s   = CNT_W'(1);
                    mem_wait_s  = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == CNT_W'(MEM_TIMEOUT)) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                    timeout_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    mem_wait_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    assign run_s      = (state_r == RUN);
    assign branch_s   = run_s && !mem_wait_s && ctrl_branch_M && ALU_zero_M;
    assign load_use_s = run_s && !mem_wait_s && !branch_s && ctrl_result_E &&
                        (reg_match(register_file_WA_E, rs1_D) ||
                         reg_match(register_file_WA_E, rs2_D));

    // Stall/flush/redirect decode; held quiet while reset is asserted.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        flush_W = 1'b0;
        pc_src  = 1'b0;
        if (!rst_n) begin
            pc_src  = 1'b0;
        end else begin
            stall_F = mem_wait_s || load_use_s;
            stall_D = mem_wait_s || load_use_s;
            stall_E = mem_wait_s;
            stall_M = mem_wait_s;
            flush_D = branch_s;
            flush_E = branch_s || load_use_s;
            flush_M = branch_s;
            flush_W = mem_wait_s || timeout_s;
            pc_src  = branch_s;
        end
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RUN;
            cnt_r     <= '0;
            mem_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mem_err_r <= mem_err_r || timeout_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;
    logic [31:0] perf_tmo_r;

    assign perf_stall_cycles = perf_stall_r;
    assign perf_flushes      = perf_flush_r;
    assign perf_timeouts     = perf_tmo_r;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
            perf_tmo_r   <= 32'd0;
        end else begin
            if (mem_wait_s || load_use_s) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if (branch_s) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
            if (timeout_s) begin
                perf_tmo_r <= perf_tmo_r + 32'd1;
            end else begin
                perf_tmo_r <= perf_tmo_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (optionally with HAZARD_PERF_CNT_EN).
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E;
    logic [4:0] wa_E, wa_M, wa_W;
    logic       we_M, we_W, ctrl_result_E, ctrl_branch_M, ALU_zero_M;
    logic       dmem_req_M, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, flush_M, flush_W;
    logic [1:0] forward_A_E, forward_B_E;
    logic       pc_src, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flushes, perf_timeouts;
`endif

    int tests_run;
    int tests_failed;

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W, pc_src}
    logic [8:0] hz;
    assign hz = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W, pc_src};

    localparam logic [8:0] HZ_NONE = 9'b000000000;
    localparam logic [8:0] HZ_MEMW = 9'b111100010;
    localparam logic [8:0] HZ_LU   = 9'b110001000;
    localparam logic [8:0] HZ_BR   = 9'b000011101;
    localparam logic [8:0] HZ_TO   = 9'b000000010;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .rs1_D                   (rs1_D),
        .rs2_D                   (rs2_D),
        .rs1_E                   (rs1_E),
        .rs2_E                   (rs2_E),
        .register_file_WA_E      (wa_E),
        .register_file_WA_M      (wa_M),
        .register_file_WA_W      (wa_W),
        .ctrl_register_file_WE_M (we_M),
        .ctrl_register_file_WE_W (we_W),
        .ctrl_result_E           (ctrl_result_E),
        .ctrl_branch_M           (ctrl_branch_M),
        .ALU_zero_M              (ALU_zero_M),
        .dmem_req_M              (dmem_req_M),
        .dmem_ready              (dmem_ready),
        .stall_F                 (stall_F),
        .stall_D                 (stall_D),
        .stall_E                 (stall_E),
        .stall_M                 (stall_M),
        .flush_D                 (flush_D),
        .flush_E                 (flush_E),
        .flush_M                 (flush_M),
        .flush_W                 (flush_W),
        .forward_A_E             (forward_A_E),
        .forward_B_E             (forward_B_E),
        .pc_src                  (pc_src),
        .mem_err                 (mem_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles       (perf_stall_cycles),
        .perf_flushes            (perf_flushes),
        .perf_timeouts           (perf_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1_D = 5'd0; rs2_D = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
        wa_E = 5'd0; wa_M = 5'd0; wa_W = 5'd0;
        we_M = 1'b0; we_W = 1'b0; ctrl_result_E = 1'b0;
        ctrl_branch_M = 1'b0; ALU_zero_M = 1'b0;
        dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL reset_hz: got %b expected %b", hz, HZ_NONE);
        end
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_err: got %b expected 0", mem_err);
        end
        dmem_req_M = 1'b1;
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL reset_req_hz: got %b expected %b", hz, HZ_NONE);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests_run++;
        if ({perf_stall_cycles, perf_flushes, perf_timeouts} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_stall_cycles, perf_flushes, perf_timeouts);
        end
`endif
        dmem_req_M = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        next_cycle();
        clear_inputs();
        wa_M = 5'd5; we_M = 1'b1; wa_W = 5'd5; we_W = 1'b1; rs1_E = 5'd5; rs2_E = 5'd6;
        #1;
        tests_run++;
        if (forward_A_E !== 2'b10 || forward_B_E !== 2'b00) begin
            tests_failed++;
            $display("FAIL fwd_m_prio: got A=%b B=%b expected A=10 B=00", forward_A_E, forward_B_E);
        end
        we_M = 1'b0;
        #1;
        tests_run++;
        if (forward_A_E !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwd_w: got %b expected 01", forward_A_E);
        end
        we_M = 1'b1; wa_M = 5'd3; wa_W = 5'd6; rs1_E = 5'd6; rs2_E = 5'd3;
        #1;
        tests_run++;
        if (forward_A_E !== 2'b01 || forward_B_E !== 2'b10) begin
            tests_failed++;
            $display("FAIL fwd_mixed: got A=%b B=%b expected A=01 B=10", forward_A_E, forward_B_E);
        end
        wa_M = 5'd0; wa_W = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
        #1;
        tests_run++;
        if (forward_A_E !== 2'b00 || forward_B_E !== 2'b00) begin
            tests_failed++;
            $display("FAIL fwd_x0: got A=%b B=%b expected A=00 B=00", forward_A_E, forward_B_E);
        end
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL fwd_no_hz: got %b expected %b", hz, HZ_NONE);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        clear_inputs();
        ctrl_result_E = 1'b1; wa_E = 5'd7; rs1_D = 5'd2; rs2_D = 5'd7;
        #1;
        tests_run++;
        if (hz !== HZ_LU) begin
            tests_failed++;
            $display("FAIL load_use_rs2: got %b expected %b", hz, HZ_LU);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL load_use_after: got %b expected %b", hz, HZ_NONE);
        end
        next_cycle();
        ctrl_result_E = 1'b1; wa_E = 5'd9; rs1_D = 5'd9; rs2_D = 5'd1;
        #1;
        tests_run++;
        if (hz !== HZ_LU) begin
            tests_failed++;
            $display("FAIL load_use_rs1: got %b expected %b", hz, HZ_LU);
        end
        next_cycle();
        wa_E = 5'd0; rs1_D = 5'd0; rs2_D = 5'd0;
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL load_use_x0: got %b expected %b", hz, HZ_NONE);
        end
        ctrl_result_E = 1'b0; wa_E = 5'd4; rs1_D = 5'd4;
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL load_use_not_load: got %b expected %b", hz, HZ_NONE);
        end
    endtask

    task automatic test_branch();
        next_cycle();
        clear_inputs();
        ctrl_branch_M = 1'b1; ALU_zero_M = 1'b1;
        ctrl_result_E = 1'b1; wa_E = 5'd7; rs2_D = 5'd7;
        #1;
        tests_run++;
        if (hz !== HZ_BR) begin
            tests_failed++;
            $display("FAIL branch_over_lu: got %b expected %b", hz, HZ_BR);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL branch_after: got %b expected %b", hz, HZ_NONE);
        end
        ctrl_branch_M = 1'b1; ALU_zero_M = 1'b0;
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL branch_not_taken: got %b expected %b", hz, HZ_NONE);
        end
    endtask

    task automatic test_mem_wait();
        next_cycle();
        clear_inputs();
        dmem_req_M = 1'b1; dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL mem_zero_wait: got %b expected %b", hz, HZ_NONE);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            dmem_req_M = 1'b1; dmem_ready = 1'b0;
            ctrl_branch_M = (c == 1); ALU_zero_M = (c == 1);
            #1;
            tests_run++;
            if (hz !== HZ_MEMW) begin
                tests_failed++;
                $display("FAIL mem_wait_c%0d: got %b expected %b", c, hz, HZ_MEMW);
            end
        end
        next_cycle();
        clear_inputs();
        dmem_req_M = 1'b1; dmem_ready = 1'b1;
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL mem_release: got %b expected %b", hz, HZ_NONE);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (hz !== HZ_NONE || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_after_release: got hz=%b err=%b expected hz=%b err=0", hz, mem_err, HZ_NONE);
        end
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 16; c++) begin
            next_cycle();
            clear_inputs();
            dmem_req_M = 1'b1;
            #1;
            tests_run++;
            if (hz !== HZ_MEMW) begin
                tests_failed++;
                $display("FAIL timeout_wait_c%0d: got %b expected %b", c, hz, HZ_MEMW);
            end
        end
        next_cycle();
        #1;
        tests_run++;
        if (hz !== HZ_TO || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_cycle: got hz=%b err=%b expected hz=%b err=0", hz, mem_err, HZ_TO);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (hz !== HZ_NONE || mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_after: got hz=%b err=%b expected hz=%b err=1", hz, mem_err, HZ_NONE);
        end
        next_cycle();
        #1;
        tests_run++;
        if (mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL mem_err_sticky: got %b expected 1", mem_err);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests_run++;
        if (perf_timeouts !== 32'd1) begin
            tests_failed++;
            $display("FAIL perf_timeouts: got %0d expected 1", perf_timeouts);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            clear_inputs();
            dmem_req_M = 1'b1;
        end
        #1;
        tests_run++;
        if (hz !== HZ_MEMW) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got %b expected %b", hz, HZ_MEMW);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (hz !== HZ_NONE || mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got hz=%b err=%b expected hz=%b err=0", hz, mem_err, HZ_NONE);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests_run++;
        if ({perf_stall_cycles, perf_flushes, perf_timeouts} !== 96'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_perf: got %0d/%0d/%0d expected 0/0/0",
                     perf_stall_cycles, perf_flushes, perf_timeouts);
        end
`endif
        next_cycle();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        #1;
        tests_run++;
        if (hz !== HZ_NONE) begin
            tests_failed++;
            $display("FAIL rst_mid_run: got %b expected %b", hz, HZ_NONE);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
